writeback_queue: RTL

//   Producer side of the register-file write port: collects results from the ALU and load paths
//   and drives RegWrite/WriteRegister/WriteData into RegisterFile, at most one write per cycle.

---
 rtl/writeback_queue.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/writeback_queue.sv
// writeback_queue: in-order result FIFO that feeds the register-file
// write port, one write per cycle, with a pending-write bitmap.
//
// Ports:
//   Clk, Reset        clock; synchronous active-high reset
//   MemValid/Ready    load result handshake (MemReg, MemData)
//   AluValid/Ready    ALU result handshake (AluReg, AluData)
//   RegWrite          registered write strobe to the register file
//   WriteRegister     registered write index
//   WriteData         registered write data
//   PendingMask       bit i set while a write to register i is
//                     queued or on the port (bit 0 always clear)
//   Count             current FIFO occupancy
module writeback_queue #(
   parameter int DEPTH          = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      MemValid,
   output logic                      MemReady,
   input  logic [REG_ADDR_WIDTH-1:0] MemReg,
   input  logic [DATA_WIDTH-1:0]     MemData,
   input  logic                      AluValid,
   output logic                      AluReady,
   input  logic [REG_ADDR_WIDTH-1:0] AluReg,
   input  logic [DATA_WIDTH-1:0]     AluData,
   output logic                      RegWrite,
   output logic [REG_ADDR_WIDTH-1:0] WriteRegister,
   output logic [DATA_WIDTH-1:0]     WriteData,
   output logic [31:0]               PendingMask,
   output logic [$clog2(DEPTH):0]    Count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // FIFO storage and bookkeeping
   logic [REG_ADDR_WIDTH-1:0] r_reg  [DEPTH];
   logic [DATA_WIDTH-1:0]     r_data [DEPTH];
   logic [AW-1:0]             r_rd;
   logic [AW-1:0]             r_wr;
   logic [CW-1:0]             r_count;

   // Register-file write port
   logic                      r_wen;
   logic [REG_ADDR_WIDTH-1:0] r_wreg;
   logic [DATA_WIDTH-1:0]     r_wdata;

   logic                      w_mem_rdy;
   logic                      w_alu_rdy;
   logic                      w_mem_enq;
   logic                      w_alu_enq;
   logic                      w_deq;
   logic [AW-1:0]             w_alu_slot;
   logic [AW-1:0]             w_wr_nxt;
   logic [CW-1:0]             w_count_nxt;
   logic [31:0]               w_pending;

   // Readiness looks only at the registered count: a dequeue in
   // the same cycle does not free a slot early. The ALU path also
   // reserves room for a concurrently offered load.
   assign w_mem_rdy = (r_count < CW'(DEPTH));
   assign w_alu_rdy = ((r_count + CW'(MemValid)) < CW'(DEPTH));

   // Writes to r0 complete the handshake but are discarded.
   assign w_mem_enq = MemValid & w_mem_rdy &
                      (MemReg != '0);
   assign w_alu_enq = AluValid & w_alu_rdy &
                      (AluReg != '0);

   assign w_deq = (r_count != '0);

   // The load is the older instruction, so it takes the first
   // free slot and the ALU result lands behind it.
   assign w_alu_slot = r_wr + AW'(w_mem_enq);
   assign w_wr_nxt   = r_wr + AW'(w_mem_enq)
                            + AW'(w_alu_enq);

   assign w_count_nxt = r_count
                      + CW'(w_mem_enq)
                      + CW'(w_alu_enq)
                      - CW'(w_deq);

   // An entry is live when its distance from the read pointer is
   // below the occupancy; modulo-DEPTH wrap falls out of the
   // AW-bit subtraction.
   always_comb begin
      logic [AW-1:0] off;
      off       = '0;
      w_pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = AW'(i) - r_rd;
         if ({1'b0, off} < r_count) begin
            w_pending[r_reg[i]] = 1'b1;
         end
      end
      if (r_wen) begin
         w_pending[r_wreg] = 1'b1;
      end
      w_pending[0] = 1'b0;
   end

   // Payload storage carries no reset; occupancy gates its use.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         if (w_mem_enq) begin
            r_reg[r_wr]  <= MemReg;
            r_data[r_wr] <= MemData;
         end
         if (w_alu_enq) begin
            r_reg[w_alu_slot]  <= AluReg;
            r_data[w_alu_slot] <= AluData;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
         r_wen   <= 1'b0;
         r_wreg  <= '0;
         r_wdata <= '0;
      end else begin
         r_wr    <= w_wr_nxt;
         r_count <= w_count_nxt;
         if (w_deq) begin
            r_wen   <= 1'b1;
            r_wreg  <= r_reg[r_rd];
            r_wdata <= r_data[r_rd];
            r_rd    <= r_rd + 1'b1;
         end else begin
            // Index and data hold so the port stays quiet.
            r_wen <= 1'b0;
         end
      end
   end

   assign MemReady      = w_mem_rdy;
   assign AluReady      = w_alu_rdy;
   assign RegWrite      = r_wen;
   assign WriteRegister = r_wreg;
   assign WriteData     = r_wdata;
   assign PendingMask   = w_pending;
   assign Count         = r_count;

`ifndef SYNTHESIS
   a_no_overflow : assert property (
      @(posedge Clk) disable iff (Reset)
      r_count <= CW'(DEPTH));

   a_r0_clear : assert property (
      @(posedge Clk) w_pending[0] == 1'b0);
`endif

endmodule
